acq_fifo: RTL and testbench



---
 rtl/acq_fifo_if.sv | 38 +++
 rtl/acq_fifo.sv | 124 ++++++++++++
 tb/tb_acq_fifo.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_fifo_if.sv
// acq_fifo_if: producer/consumer bundle for the acquisition FIFO.
// master drives requests and thresholds; slave is the FIFO itself.
interface acq_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
);
  logic                  clr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [ADDR_WIDTH:0]   level;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   afull_thr;
  logic [ADDR_WIDTH:0]   aempty_thr;
  logic                  afull;
  logic                  aempty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    output afull_thr, aempty_thr,
    input  rd_data, rd_valid, level,
    input  full, empty, afull, aempty,
    input  overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    input  afull_thr, aempty_thr,
    output rd_data, rd_valid, level,
    output full, empty, afull, aempty,
    output overflow, underflow
  );
endinterface

// File: rtl/acq_fifo.sv
// acq_fifo: synchronous FIFO with level, thresholds, sticky errors.
// Define ACQ_FIFO_FWFT_EN for first-word-fall-through reads.
module acq_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input logic       clk,
  input logic       rst_a,
  acq_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;

  logic full_w;
  logic empty_w;
  logic wr_ok;
  logic pop;
  logic load;

  assign full_w  = (level_q == DEPTH_L);
  assign empty_w = (level_q == '0);

`ifdef ACQ_FIFO_FWFT_EN
  // words still in memory, excluding the one in the output register
  logic [ADDR_WIDTH:0] mem_cnt;
  assign mem_cnt = level_q - LW'(rd_valid_q);
  assign pop     = bus.rd_en && rd_valid_q;
  assign load    = (mem_cnt != '0) && (!rd_valid_q || pop);
`else
  assign pop  = bus.rd_en && !empty_w;
  assign load = pop;
`endif

  assign wr_ok = bus.wr_en && (!full_w || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    if (bus.clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      rd_valid_d = 1'b0;
      ovf_d      = 1'b0;
      udf_d      = 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr_d = wr_ptr_q + 1'b1;
      if (load) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem_q[rd_ptr_q];
      end
      unique case ({wr_ok, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
`ifdef ACQ_FIFO_FWFT_EN
      if (load)
        rd_valid_d = 1'b1;
      else if (pop)
        rd_valid_d = 1'b0;
`else
      rd_valid_d = load;
`endif
      if (bus.wr_en && !wr_ok)
        ovf_d = 1'b1;
      if (bus.rd_en && !pop)
        udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  // storage array carries no reset; contents are don't-care
  always_ff @(posedge clk) begin
    if (wr_ok && !bus.clr)
      mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.level     = level_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.afull     = (level_q >= bus.afull_thr);
  assign bus.aempty    = (level_q <= bus.aempty_thr);
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
endmodule

// File: tb/tb_acq_fifo.sv
// tb_acq_fifo: vector table, directed corners and random traffic
// against a queue-based reference of the FIFO behaviour.
module tb_acq_fifo;
  localparam int DW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  int   checks = 0;
  int   errors = 0;

  acq_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  acq_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_a (rst_a),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [15:0] wd;
    bit          re;
    bit          cl;
    logic [5:0]  aft;
    logic [5:0]  aet;
    logic [5:0]  lvl;
    bit          ful;
    bit          emp;
    bit          af;
    bit          ae;
    bit          ovf;
    bit          udf;
    bit          rv;
    logic [15:0] rd;
  } vec_t;

  vec_t tv[10];

  logic [15:0] mq[$];
  bit          m_ovf;
  bit          m_udf;
  bit          m_rv;
  logic [15:0] m_rd;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick(input bit we, input logic [15:0] wd,
                      input bit re, input bit cl);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    bus.clr     = cl;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr   = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rv  = 1'b0;
    m_rd  = '0;
  endtask

  // FIFO rules: pop then push, so write+read at full fits
  task automatic model_step(input bit we, input logic [15:0] wd,
                            input bit re, input bit cl);
    bit r_ok;
    bit w_ok;
    if (cl) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      r_ok = re && (mq.size() > 0);
      w_ok = we && ((mq.size() < DEPTH) || r_ok);
      if (re && !r_ok) m_udf = 1'b1;
      if (we && !w_ok) m_ovf = 1'b1;
      if (r_ok) m_rd = mq.pop_front();
      m_rv = r_ok;
      if (w_ok) mq.push_back(wd);
    end
  endtask

  task automatic compare_all();
    int n;
    n = mq.size();
    check("level", 32'(bus.level), 32'(n));
    check("full", 32'(bus.full), 32'(n == DEPTH));
    check("empty", 32'(bus.empty), 32'(n == 0));
    check("afull", 32'(bus.afull),
          32'(n >= int'(bus.afull_thr)));
    check("aempty", 32'(bus.aempty),
          32'(n <= int'(bus.aempty_thr)));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("underflow", 32'(bus.underflow), 32'(m_udf));
    check("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
    check("rd_data", 32'(bus.rd_data), 32'(m_rd));
  endtask

  task automatic cyc(input bit we, input logic [15:0] wd,
                     input bit re, input bit cl);
    model_step(we, wd, re, cl);
    tick(we, wd, re, cl);
    compare_all();
  endtask

  // async pulse placed between clock edges
  task automatic async_rst();
    #2 rst_a = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1 rst_a = 1'b0;
  endtask

  function automatic vec_t mk(bit we, logic [15:0] wd, bit re,
                              bit cl, logic [5:0] aft,
                              logic [5:0] aet, logic [5:0] lvl,
                              bit ful, bit emp, bit af, bit ae,
                              bit ovf, bit udf, bit rv,
                              logic [15:0] rd);
    vec_t v;
    v.we = we; v.wd = wd; v.re = re; v.cl = cl;
    v.aft = aft; v.aet = aet; v.lvl = lvl;
    v.ful = ful; v.emp = emp; v.af = af; v.ae = ae;
    v.ovf = ovf; v.udf = udf; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  initial begin
    logic [15:0] d;
    int pw;
    int pr;

    tv[0] = mk(1, 16'h1111, 0, 0, 2,  0, 1, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
    tv[1] = mk(1, 16'h2222, 0, 0, 2,  0, 2, 0, 0, 1, 0, 0, 0, 0, 16'h0000);
    tv[2] = mk(0, 16'h0000, 1, 0, 2,  0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h1111);
    tv[3] = mk(1, 16'h3333, 1, 0, 2,  0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h2222);
    tv[4] = mk(0, 16'h0000, 1, 0, 2,  0, 0, 0, 1, 0, 1, 0, 0, 1, 16'h3333);
    tv[5] = mk(0, 16'h0000, 1, 0, 2,  0, 0, 0, 1, 0, 1, 0, 1, 0, 16'h3333);
    tv[6] = mk(1, 16'h4444, 1, 0, 2,  0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h3333);
    tv[7] = mk(0, 16'h0000, 0, 0, 0,  1, 1, 0, 0, 1, 1, 0, 1, 0, 16'h3333);
    tv[8] = mk(0, 16'h0000, 0, 0, 33, 0, 1, 0, 0, 0, 0, 0, 1, 0, 16'h3333);
    tv[9] = mk(1, 16'h5555, 0, 1, 2,  0, 0, 0, 1, 0, 1, 0, 0, 0, 16'h3333);

    bus.clr        = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.rd_en      = 1'b0;
    bus.afull_thr  = 6'd28;
    bus.aempty_thr = 6'd3;
    model_reset();
    #2;
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_rv", 32'(bus.rd_valid), 32'd0);
    check("rst_rd", 32'(bus.rd_data), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_udf", 32'(bus.underflow), 32'd0);
    check("rst_afull", 32'(bus.afull), 32'd0);
    check("rst_aempty", 32'(bus.aempty), 32'd1);
    @(negedge clk);
    rst_a = 1'b0;

`ifdef ACQ_FIFO_FWFT_EN
    tick(1, 16'h00A5, 0, 0);
    check("fw_rv0", 32'(bus.rd_valid), 32'd0);
    check("fw_empty0", 32'(bus.empty), 32'd0);
    check("fw_lvl1", 32'(bus.level), 32'd1);
    tick(0, 16'h0000, 0, 0);
    check("fw_rv1", 32'(bus.rd_valid), 32'd1);
    check("fw_rdA5", 32'(bus.rd_data), 32'h00A5);
    check("fw_lvl1b", 32'(bus.level), 32'd1);
    tick(1, 16'h00A6, 0, 0);
    check("fw_lvl2", 32'(bus.level), 32'd2);
    check("fw_rdA5b", 32'(bus.rd_data), 32'h00A5);
    tick(0, 16'h0000, 1, 0);
    check("fw_rdA6", 32'(bus.rd_data), 32'h00A6);
    check("fw_rv_hold", 32'(bus.rd_valid), 32'd1);
    check("fw_lvl1c", 32'(bus.level), 32'd1);
    tick(0, 16'h0000, 1, 0);
    check("fw_rv_drop", 32'(bus.rd_valid), 32'd0);
    check("fw_empty", 32'(bus.empty), 32'd1);
    check("fw_udf0", 32'(bus.underflow), 32'd0);
    tick(0, 16'h0000, 1, 0);
    check("fw_udf1", 32'(bus.underflow), 32'd1);
`else
    foreach (tv[i]) begin
      bus.afull_thr  = tv[i].aft;
      bus.aempty_thr = tv[i].aet;
      tick(tv[i].we, tv[i].wd, tv[i].re, tv[i].cl);
      check($sformatf("tv%0d_lvl", i),
            32'(bus.level), 32'(tv[i].lvl));
      check($sformatf("tv%0d_full", i),
            32'(bus.full), 32'(tv[i].ful));
      check($sformatf("tv%0d_empty", i),
            32'(bus.empty), 32'(tv[i].emp));
      check($sformatf("tv%0d_afull", i),
            32'(bus.afull), 32'(tv[i].af));
      check($sformatf("tv%0d_aempty", i),
            32'(bus.aempty), 32'(tv[i].ae));
      check($sformatf("tv%0d_ovf", i),
            32'(bus.overflow), 32'(tv[i].ovf));
      check($sformatf("tv%0d_udf", i),
            32'(bus.underflow), 32'(tv[i].udf));
      check($sformatf("tv%0d_rv", i),
            32'(bus.rd_valid), 32'(tv[i].rv));
      check($sformatf("tv%0d_rd", i),
            32'(bus.rd_data), 32'(tv[i].rd));
    end

    bus.afull_thr  = 6'd28;
    bus.aempty_thr = 6'd3;
    async_rst();

    for (int i = 1; i <= 32; i++)
      cyc(1, 16'(i), 0, 0);
    check("fill_level", 32'(bus.level), 32'd32);
    check("fill_full", 32'(bus.full), 32'd1);
    cyc(1, 16'hFFFF, 0, 0);
    check("ovf_set", 32'(bus.overflow), 32'd1);
    check("ovf_level", 32'(bus.level), 32'd32);

    for (int i = 1; i <= 32; i++) begin
      cyc(0, 16'h0, 1, 0);
      check("drain_data", 32'(bus.rd_data), 32'(i));
    end
    check("drain_empty", 32'(bus.empty), 32'd1);
    cyc(0, 16'h0, 1, 0);
    check("udf_set", 32'(bus.underflow), 32'd1);
    check("udf_hold", 32'(bus.rd_data), 32'h0020);

    cyc(0, 16'h0, 0, 1);
    d = 16'h0100;
    for (int i = 0; i < 16; i++) begin
      cyc(1, d, 0, 0);
      d++;
    end
    for (int i = 0; i < 100; i++) begin
      cyc(1, d, 1, 0);
      d++;
    end
    check("sus16_level", 32'(bus.level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(1, d, 0, 0);
      d++;
    end
    for (int i = 0; i < 100; i++) begin
      cyc(1, d, 1, 0);
      d++;
    end
    check("sus32_level", 32'(bus.level), 32'd32);
    check("sus32_ovf", 32'(bus.overflow), 32'd0);

    cyc(1, 16'hBEEF, 0, 0);
    for (int i = 0; i < 22; i++)
      cyc(0, 16'h0, 1, 0);
    check("pre_clr_lvl", 32'(bus.level), 32'd10);
    cyc(1, 16'hDEAD, 0, 1);
    check("clr_level", 32'(bus.level), 32'd0);
    check("clr_ovf", 32'(bus.overflow), 32'd0);

    for (int i = 0; i < 5; i++)
      cyc(1, 16'(16'h0A00 + i), i[0], 0);
    async_rst();
    cyc(1, 16'h0777, 0, 0);
    check("post_rst_wr", 32'(bus.level), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        bus.afull_thr  = 6'($urandom_range(40));
        bus.aempty_thr = 6'($urandom_range(40));
      end
      unique case ((i / 200) % 3)
        0:       begin pw = 75; pr = 25; end
        1:       begin pw = 25; pr = 75; end
        default: begin pw = 50; pr = 50; end
      endcase
      cyc($urandom_range(99) < pw, 16'($urandom),
          $urandom_range(99) < pr, $urandom_range(199) == 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
